// File: rtl/gru_seq_pkg.sv
// Shared types and constants for the GRU sequence controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gru_seq_pkg;

  // Controller states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT_X = 3'd1,
    SETTLE = 3'd2,
    OUT    = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Config addresses of the weight/bias registers
  localparam logic [3:0] ADDR_WZ = 4'd0;
  localparam logic [3:0] ADDR_WR = 4'd1;
  localparam logic [3:0] ADDR_WH = 4'd2;
  localparam logic [3:0] ADDR_UZ = 4'd3;
  localparam logic [3:0] ADDR_UR = 4'd4;
  localparam logic [3:0] ADDR_UH = 4'd5;
  localparam logic [3:0] ADDR_BZ = 4'd6;
  localparam logic [3:0] ADDR_BR = 4'd7;
  localparam logic [3:0] ADDR_BH = 4'd8;

  localparam int NUM_WEIGHTS = 9;

endpackage

// File: rtl/gru_seq_wregs.sv
// Nine-entry weight/bias register file with address decode.
// Latency: a write is visible on w the cycle after the write strobe.
// Backpressure: none; the caller qualifies we (addresses 9..15 are ignored).
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   we         : qualified write strobe
//   addr       : register select 0..8
//   wdata      : write data
//   w          : all register values, index = config address
module gru_seq_wregs
  import gru_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   we,
  input  logic [3:0]                             addr,
  input  logic [DATA_WIDTH-1:0]                  wdata,
  output logic [NUM_WEIGHTS-1:0][DATA_WIDTH-1:0] w
);

  // Compare against every entry rather than indexing, so out-of-range
  // addresses simply match nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w <= '0;
    end else if (we) begin
      for (int i = 0; i < NUM_WEIGHTS; i++) begin
        if (addr == 4'(i)) begin
          w[i] <= wdata;
        end
      end
    end
  end

endmodule

// File: rtl/gru_seq_ctrl.sv
// Sequencer running the combinational GRU cell over a stream of samples,
// feeding each hidden state back and emitting it downstream.
// Latency: x handshake in cycle T -> y_valid in cycle T+SETTLE_CYC+1.
// Backpressure: y held stable until y_ready; x_ready only high in WAIT_X.
//
// Optional build macro GRU_SEQ_LAST_ONLY_EN: only the final step of a
// sequence is emitted on the y stream (intermediate steps loop straight
// back to WAIT_X).
//
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   cfg_we/addr/wdata    : weight/bias writes, accepted when cfg_ready
//   start/seq_len/h_init : launch a sequence (ignored while busy)
//   abort                : synchronous cancel, returns to IDLE
//   x_*                  : input sample stream (valid/ready)
//   y_*                  : hidden-state result stream (valid/ready, last)
//   busy, done           : status; done pulses once at sequence end
//   cell_*               : registered drives to / result from the cell
module gru_seq_ctrl
  import gru_seq_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int FRACT_WIDTH = 5,
  parameter int SETTLE_CYC  = 2,
  parameter int LEN_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_we,
  input  logic [3:0]            cfg_addr,
  input  logic [DATA_WIDTH-1:0] cfg_wdata,
  output logic                  cfg_ready,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  seq_len,
  input  logic [DATA_WIDTH-1:0] h_init,
  input  logic                  abort,
  input  logic                  x_valid,
  input  logic [DATA_WIDTH-1:0] x_data,
  output logic                  x_ready,
  output logic                  y_valid,
  output logic [DATA_WIDTH-1:0] y_data,
  output logic                  y_last,
  input  logic                  y_ready,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] cell_x,
  output logic [DATA_WIDTH-1:0] cell_h_in,
  output logic [DATA_WIDTH-1:0] cell_wz,
  output logic [DATA_WIDTH-1:0] cell_wr,
  output logic [DATA_WIDTH-1:0] cell_wh,
  output logic [DATA_WIDTH-1:0] cell_uz,
  output logic [DATA_WIDTH-1:0] cell_ur,
  output logic [DATA_WIDTH-1:0] cell_uh,
  output logic [DATA_WIDTH-1:0] cell_bz,
  output logic [DATA_WIDTH-1:0] cell_br,
  output logic [DATA_WIDTH-1:0] cell_bh,
  input  logic [DATA_WIDTH-1:0] cell_h_out
);

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  // FRACT_WIDTH only describes the value format; reject nonsense settings.
  if (SETTLE_CYC < 1 || FRACT_WIDTH >= DATA_WIDTH) begin : g_param_check
    $error("gru_seq_ctrl: SETTLE_CYC must be >= 1 and FRACT_WIDTH < DATA_WIDTH");
  end

  state_t                state_q, state_nxt;
  logic [LEN_WIDTH-1:0]  len_q, step_q;
  logic [DATA_WIDTH-1:0] h_state_q, x_reg_q, y_data_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  zero_done_q;  // done pulse for a zero-length start
  logic                  rst_done_q;   // holds cfg_ready low until out of reset
  logic                  is_last;
  logic                  settle_end;

  logic [NUM_WEIGHTS-1:0][DATA_WIDTH-1:0] w;

  assign is_last    = (step_q == len_q - LEN_WIDTH'(1));
  assign settle_end = (state_q == SETTLE) && (cnt_q == '0);

  // ---------------------------------------------------------------------
  // Weight/bias registers; writes are only taken while idle.
  // ---------------------------------------------------------------------
  gru_seq_wregs #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_wregs (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (cfg_we & cfg_ready),
    .addr  (cfg_addr),
    .wdata (cfg_wdata),
    .w     (w)
  );

  assign cell_wz   = w[ADDR_WZ];
  assign cell_wr   = w[ADDR_WR];
  assign cell_wh   = w[ADDR_WH];
  assign cell_uz   = w[ADDR_UZ];
  assign cell_ur   = w[ADDR_UR];
  assign cell_uh   = w[ADDR_UH];
  assign cell_bz   = w[ADDR_BZ];
  assign cell_br   = w[ADDR_BR];
  assign cell_bh   = w[ADDR_BH];
  assign cell_x    = x_reg_q;
  assign cell_h_in = h_state_q;
  assign y_data    = y_data_q;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state (abort overrides every transition)
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state_q;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      unique case (state_q)
        IDLE:   if (start && seq_len != '0) state_nxt = WAIT_X;
        WAIT_X: if (x_valid) state_nxt = SETTLE;
        SETTLE: begin
          if (cnt_q == '0) begin
`ifdef GRU_SEQ_LAST_ONLY_EN
            state_nxt = is_last ? OUT : WAIT_X;
`else
            state_nxt = OUT;
`endif
          end
        end
        OUT:    if (y_ready) state_nxt = is_last ? DONE : WAIT_X;
        DONE:   state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // FSM: outputs. Handshakes are masked during abort so neither side
  // believes a transfer happened that the controller then discards.
  // ---------------------------------------------------------------------
  always_comb begin
    busy      = (state_q != IDLE);
    cfg_ready = (state_q == IDLE) && rst_done_q;
    x_ready   = (state_q == WAIT_X) && !abort;
    y_valid   = (state_q == OUT) && !abort;
    y_last    = (state_q == OUT) && !abort && is_last;
    done      = ((state_q == DONE) || zero_done_q) && !abort;
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q       <= '0;
      step_q      <= '0;
      h_state_q   <= '0;
      x_reg_q     <= '0;
      y_data_q    <= '0;
      cnt_q       <= '0;
      zero_done_q <= 1'b0;
      rst_done_q  <= 1'b0;
    end else begin
      rst_done_q  <= 1'b1;
      zero_done_q <= !abort && (state_q == IDLE) && start && (seq_len == '0);
      if (!abort) begin
        unique case (state_q)
          IDLE: begin
            if (start && seq_len != '0) begin
              len_q     <= seq_len;
              h_state_q <= h_init;
              step_q    <= '0;
            end
          end
          WAIT_X: begin
            if (x_valid) begin
              x_reg_q <= x_data;
              cnt_q   <= CNT_W'(SETTLE_CYC - 1);
            end
          end
          SETTLE: begin
            if (settle_end) begin
              y_data_q  <= cell_h_out;
              h_state_q <= cell_h_out;
`ifdef GRU_SEQ_LAST_ONLY_EN
              if (!is_last) step_q <= step_q + LEN_WIDTH'(1);
`endif
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          OUT: begin
            if (y_ready && !is_last) step_q <= step_q + LEN_WIDTH'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gru_seq_ctrl.sv
// Self-checking bench for gru_seq_ctrl with an adder stub as the cell.
// Latency: n/a.
// Backpressure: y_ready driven by the bench.
module tb_gru_seq_ctrl;
  import gru_seq_pkg::*;

  localparam int DW = 8;
  localparam int LW = 8;
  localparam int SC = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [3:0]    cfg_addr = '0;
  logic [DW-1:0] cfg_wdata = '0;
  logic          cfg_ready;
  logic          start = 1'b0;
  logic [LW-1:0] seq_len = '0;
  logic [DW-1:0] h_init = '0;
  logic          abort = 1'b0;
  logic          x_valid = 1'b0;
  logic [DW-1:0] x_data = '0;
  logic          x_ready;
  logic          y_valid;
  logic [DW-1:0] y_data;
  logic          y_last;
  logic          y_ready = 1'b1;
  logic          busy, done;
  logic [DW-1:0] cell_x, cell_h_in, cell_wz, cell_wr, cell_wh, cell_uz, cell_ur;
  logic [DW-1:0] cell_uh, cell_bz, cell_br, cell_bh, cell_h_out;

  // Stub cell: h_out = x + h_in (mod 256)
  assign cell_h_out = cell_x + cell_h_in;

  gru_seq_ctrl #(
    .DATA_WIDTH(DW), .FRACT_WIDTH(5), .SETTLE_CYC(SC), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_ready(cfg_ready),
    .start(start), .seq_len(seq_len), .h_init(h_init), .abort(abort),
    .x_valid(x_valid), .x_data(x_data), .x_ready(x_ready),
    .y_valid(y_valid), .y_data(y_data), .y_last(y_last), .y_ready(y_ready),
    .busy(busy), .done(done),
    .cell_x(cell_x), .cell_h_in(cell_h_in),
    .cell_wz(cell_wz), .cell_wr(cell_wr), .cell_wh(cell_wh),
    .cell_uz(cell_uz), .cell_ur(cell_ur), .cell_uh(cell_uh),
    .cell_bz(cell_bz), .cell_br(cell_br), .cell_bh(cell_bh),
    .cell_h_out(cell_h_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard of expected y beats
  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;
  exp_t sbq[$];

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && y_valid && y_ready) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_y: got y_data=%0d y_last=%0d expected no beat", y_data, y_last);
      end else begin
        e = sbq.pop_front();
        check("y_data", int'(y_data), int'(e.data));
        check("y_last", int'(y_last), int'(e.last));
      end
    end
  end

  function automatic logic [DW-1:0] get_w(input int i);
    case (i)
      0: return cell_wz;
      1: return cell_wr;
      2: return cell_wh;
      3: return cell_uz;
      4: return cell_ur;
      5: return cell_uh;
      6: return cell_bz;
      7: return cell_br;
      default: return cell_bh;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [DW-1:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic start_seq(input logic [LW-1:0] n, input logic [DW-1:0] h0);
    start = 1'b1; seq_len = n; h_init = h0;
    tick();
    start = 1'b0;
  endtask

  // Offers one sample; hs_cyc is the cycle in which the handshake happened.
  task automatic send_x(input logic [DW-1:0] x, output int hs_cyc);
    bit ok = 0;
    hs_cyc = -1;
    x_valid = 1'b1; x_data = x;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (x_ready) begin
        hs_cyc = cyc;
        ok = 1;
        break;
      end
    end
    tick();
    x_valid = 1'b0;
    if (!ok) check("x_handshake_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && sbq.size() != 0; i++) tick();
    if (sbq.size() != 0) begin
      check("y_drain_timeout", sbq.size(), 0);
      sbq.delete();
    end
  endtask

  task automatic push_exp(input logic [DW-1:0] d, input logic last);
`ifdef GRU_SEQ_LAST_ONLY_EN
    if (last) sbq.push_back('{d, last});
`else
    sbq.push_back('{d, last});
`endif
  endtask

  // Config vectors: write, then expect register idx to read exp
  typedef struct {
    logic [3:0]    addr;
    logic [DW-1:0] wdata;
    int            idx;
    logic [DW-1:0] exp;
  } cfg_vec_t;

  // Sequence vectors: inputs and expected hidden states (default mode)
  typedef struct {
    int            len;
    logic [DW-1:0] h0;
    logic [DW-1:0] xs[3];
    logic [DW-1:0] ys[3];
  } seq_vec_t;

  logic [DW-1:0] w_model[NUM_WEIGHTS];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cfg_vec_t cv[10];
    seq_vec_t sv[3];
    int hs;
    int vcyc;

    for (int i = 0; i < NUM_WEIGHTS; i++) cv[i] = '{4'(i), DW'(i + 1), i, DW'(i + 1)};
    cv[9] = '{4'd12, 8'h55, 0, 8'd1};
    sv[0] = '{3, 8'd0, '{8'd4, 8'd5, 8'd6},   '{8'd4, 8'd9, 8'd15}};
    sv[1] = '{3, 8'd0, '{8'd1, 8'd1, 8'd1},   '{8'd1, 8'd2, 8'd3}};
    sv[2] = '{2, 8'd7, '{8'd250, 8'd10, 8'd0}, '{8'd1, 8'd11, 8'd0}};
    for (int i = 0; i < NUM_WEIGHTS; i++) w_model[i] = '0;

    // ---- reset ----
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_x_ready", x_ready, 0);
    check("rst_y_valid", y_valid, 0);
    check("rst_y_data", y_data, 0);
    check("rst_done", done, 0);
    check("rst_cell_wz", cell_wz, 0);
    check("rst_cell_bh", cell_bh, 0);
    check("rst_cell_h_in", cell_h_in, 0);
    check("rst_cfg_ready", cfg_ready, 1);

    // ---- config table ----
    tick();
    for (int i = 0; i < 10; i++) begin
      cfg_write(cv[i].addr, cv[i].wdata);
      if (cv[i].addr < 4'(NUM_WEIGHTS)) w_model[cv[i].addr] = cv[i].wdata;
      @(negedge clk);
      check("cfg_reg", int'(get_w(cv[i].idx)), int'(cv[i].exp));
      tick();
    end
    for (int i = 0; i < NUM_WEIGHTS; i++) check("cfg_all", int'(get_w(i)), int'(w_model[i]));

    // ---- sequence table ----
    y_ready = 1'b1;
    for (int v = 0; v < 3; v++) begin
      start_seq(LW'(sv[v].len), sv[v].h0);
      for (int s = 0; s < sv[v].len; s++) begin
        push_exp(sv[v].ys[s], s == sv[v].len - 1);
        send_x(sv[v].xs[s], hs);
        wait_drain();
      end
      @(negedge clk);
      check("seq_done_pulse", done, 1);
      @(negedge clk);
      check("seq_done_cleared", done, 0);
      check("seq_busy_cleared", busy, 0);
      tick();
    end

    // ---- latency and backpressure ----
    y_ready = 1'b0;
    start_seq(8'd1, 8'd10);
    push_exp(8'd13, 1'b1);
    send_x(8'd3, hs);
    vcyc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (y_valid) begin
        vcyc = cyc;
        break;
      end
    end
    check("latency", vcyc - hs, SC + 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_y_valid", y_valid, 1);
      check("hold_y_data", y_data, 13);
      check("hold_x_ready", x_ready, 0);
    end
    @(posedge clk);
    #1 y_ready = 1'b1;
    wait_drain();
    @(negedge clk);
    check("bp_done_pulse", done, 1);
    tick();

    // ---- zero-length start ----
    start_seq(8'd0, 8'd0);
    @(negedge clk);
    check("zero_done_pulse", done, 1);
    check("zero_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("zero_done_after", done, 0);
      check("zero_busy_after", busy, 0);
      check("zero_y_valid", y_valid, 0);
    end
    tick();

    // ---- abort during SETTLE of step 2, with a dropped cfg write ----
    start_seq(8'd3, 8'd0);
    push_exp(8'd1, 1'b0);
    send_x(8'd1, hs);
    wait_drain();
    send_x(8'd2, hs);             // now in SETTLE
    check("busy_cfg_ready", cfg_ready, 0);
    cfg_write(ADDR_WZ, 8'h20);    // dropped while busy
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_y_valid", y_valid, 0);
    check("abort_x_ready", x_ready, 0);
    check("abort_done", done, 0);
    check("abort_cell_wz", cell_wz, int'(w_model[0]));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end
    check("abort_cfg_ready", cfg_ready, 1);
    check("abort_sb_empty", sbq.size(), 0);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gru_seq_ctrl.md
Name: gru_seq_ctrl

Overview:
- Sequencer that runs the combinational gru_lstm_cell over a time sequence of 8-bit Q3.5 samples.
- Holds the nine weight/bias registers, written through a config port.
- Accepts inputs X over a valid/ready stream, drives the cell, waits a fixed settle time, then captures h_out.
- Feeds h_out back as h_in for the next step and emits each hidden state on an output stream. It sits between the sample source and the downstream consumer, with the cell instantiated beside it.

Parameters:
- DATA_WIDTH, 8, width of all data, weight and bias values (signed, two's complement).
- FRACT_WIDTH, 5, fractional bits; informational only, controller does no arithmetic on values.
- SETTLE_CYC, 2, cycles the cell inputs are held stable before h_out is sampled; minimum 1.
- LEN_WIDTH, 8, width of sequence-length and step counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  config write strobe
- cfg_addr  in  4  0..8 selects Wz,Wr,Wh,Uz,Ur,Uh,bz,br,bh
- cfg_wdata  in  DATA_WIDTH  config write data
- cfg_ready  out  1  config writes accepted (high when not busy)
- start  in  1  one-cycle sequence start
- seq_len  in  LEN_WIDTH  number of steps, sampled on start
- h_init  in  DATA_WIDTH  initial hidden state, sampled on start
- abort  in  1  synchronous cancel
- x_valid  in  1  input sample valid
- x_data  in  DATA_WIDTH  input sample
- x_ready  out  1  controller accepts sample
- y_valid  out  1  hidden-state result valid
- y_data  out  DATA_WIDTH  hidden state of current step
- y_last  out  1  marks final step of sequence
- y_ready  in  1  downstream accepts result
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at sequence end
- cell_x, cell_h_in, cell_wz, cell_wr, cell_wh, cell_uz, cell_ur, cell_uh, cell_bz, cell_br, cell_bh  out  DATA_WIDTH each  registered drives to the cell
- cell_h_out  in  DATA_WIDTH  cell result

Behaviour:
- Reset: all registers, counters, weights and outputs 0; state IDLE. cfg_ready goes 1 after reset.
- Config: write occurs on clk when cfg_we & cfg_ready. Addresses 9..15 are ignored. Writes while busy are dropped and have no effect.
- States:
  - IDLE: busy=0, x_ready=0.
    - start & seq_len!=0: latch len, h_state<=h_init, step<=0, go WAIT_X.
    - start & seq_len==0: done pulses next cycle, stay IDLE, no y output.
  - WAIT_X: x_ready=1. On x_valid handshake, x_reg<=x_data, cnt<=SETTLE_CYC-1, go SETTLE.
  - SETTLE: cell inputs are stable. When cnt==0: y_data<=cell_h_out, h_state<=cell_h_out, go OUT. Otherwise decrement cnt.
  - OUT: y_valid=1, y_last=(step==len-1). Outputs are held stable until y_ready.
    - On handshake with y_last: go DONE.
    - On handshake otherwise: step++, go WAIT_X.
  - DONE: done=1 for one cycle, then IDLE. h_state and y_data are retained.
- Latency: x handshake in cycle T gives y_valid in cycle T+SETTLE_CYC+1.
- start while busy is ignored. busy=1 in every state except IDLE.
- abort has priority over all transitions: next state IDLE, y_valid/x_ready deassert, no done pulse, weights retained.
- Async reset mid-sequence returns to the reset state immediately.
- cell_h_in=h_state, cell_x=x_reg. Weights are driven straight from their registers.
- step counter does not wrap: seq_len=2^LEN_WIDTH-1 runs exactly that many steps.

Optional Feature:
- GRU_SEQ_LAST_ONLY_EN defined: intermediate steps skip OUT and go directly WAIT_X (step++). Only the final step asserts y_valid (with y_last=1).
- Undefined: every step is emitted as above.

Decomposition:
- Package gru_seq_pkg holds:
  - state enum (IDLE, WAIT_X, SETTLE, OUT, DONE)
  - cfg address constants ADDR_WZ..ADDR_BH (0..8)
  - NUM_WEIGHTS=9
- Optional sub-module gru_seq_wregs: the nine-entry weight/bias register file with write decode.

Test Plan:
- Bench stub cell: cell_h_out = cell_x + cell_h_in mod 256.
- Reset, then write Wz..bh = 1..9 -> cell_wz..cell_bh read 1..9. Write to addr 12 -> no register changes.
- seq_len=3, h_init=0, x=4,5,6 with y_ready=1 -> y_data 4,9,15. y_last only on the third. done one cycle after the third handshake.
- SETTLE_CYC=2, x handshake at cycle 10 -> y_valid first high at cycle 13. Hold y_ready=0 for 5 cycles -> y_data stable, x_ready=0.
- start with seq_len=0 -> done pulse next cycle, y_valid never asserts, busy stays 0.
- abort during SETTLE of step 2 -> IDLE next cycle, no done. cfg write of 0x20 to addr 0 during busy is dropped; cfg_wz unchanged.
- GRU_SEQ_LAST_ONLY_EN, seq_len=3, x=1,1,1 -> single y_valid with y_data=3, y_last=1.
